ibex_multdiv_issue_ctrl: RTL
============================

Name: ibex_multdiv_issue_ctrl

Overview:
Initiator side of the fast multiply/divide interface. It accepts one M-extension request per handshake from the decoder and drives the enable/select/operand bus of the multdiv unit. It owns the two 34-bit intermediate-value registers and supplies the shared 33-bit adder and the zero-detect that the multdiv unit borrows. It captures the result on the unit's valid and presents it to writeback through a valid/ready handshake.

Parameters:
DATA_W, 32, operand/result width (fixed; other values unsupported)
IMD_W, 34, width of each intermediate-value register

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
req_valid_i  in  1  decoder request valid
req_ready_o  out  1  request accepted this cycle
req_op_i  in  2  0=MULL 1=MULH 2=DIV 3=REM
req_signed_i  in  2  [0] op_a signed, [1] op_b signed
req_a_i  in  32  operand A
req_b_i  in  32  operand B
req_dit_i  in  1  data-independent-timing request
flush_i  in  1  kill in-flight/pending op
mult_en_o  out  1  multiply enable to unit
div_en_o  out  1  divide enable to unit
mult_sel_o  out  1  multiply selected
div_sel_o  out  1  divide selected
operator_o  out  2  latched op
signed_mode_o  out  2  latched signedness
op_a_o  out  32  latched A
op_b_o  out  32  latched B
data_ind_timing_o  out  1  latched DIT
alu_operand_a_i  in  33  adder input A from unit
alu_operand_b_i  in  33  adder input B from unit
alu_adder_ext_o  out  34  zero-extended A+B
alu_adder_o  out  32  alu_adder_ext_o[32:1]
equal_to_zero_o  out  1  op_b_o == 0
imd_val_d_i  in  68  intermediate write data
imd_val_we_i  in  2  intermediate write enables
imd_val_q_o  out  68  intermediate register contents
valid_i  in  1  unit result valid
result_i  in  32  unit result
multdiv_ready_id_o  out  1  controller can take result
wb_valid_o  out  1  writeback data valid
wb_ready_i  in  1  writeback accepts
wb_data_o  out  32  result to writeback
busy_o  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, kill=0, all latched fields, imd regs and wb_data = 0. All enables and valids are 0. req_ready_o = 1.
- States: IDLE, EXEC, RESP.
- IDLE: req_ready_o=1. On req_valid_i, latch op/signed/A/B/DIT and go to EXEC. Enables are 0 in IDLE.
- EXEC: mult_en_o=mult_sel_o=(op<2) and div_en_o=div_sel_o=(op>=2). multdiv_ready_id_o=1. req_ready_o=0. Latched fields are held stable throughout.
- EXEC with valid_i=1: capture result_i into wb_data and drop the enables the next cycle.
  - If kill or flush_i is set that cycle, go to IDLE with no wb_valid.
  - Otherwise go to RESP.
- Latency from valid_i to wb_valid_o is 1 cycle. The unit reaches its idle state on the same edge because ready_id=1.
- flush_i in EXEC sets kill. The op runs to completion and is never aborted mid-sequence, because the unit's internal FSMs only advance while enabled. The result is then discarded. kill clears on leaving EXEC.
- RESP: wb_valid_o=1 and wb_data_o is held.
  - flush_i: go to IDLE, wb_valid_o low next cycle.
  - wb_ready_i: handshake completes. req_ready_o=wb_ready_i, so a new request is accepted on the same edge (back-to-back) and goes to EXEC; otherwise go to IDLE.
- imd regs: imd_val_q_o[67:34] is written with imd_val_d_i[67:34] when we_i[0]. imd_val_q_o[33:0] is written with imd_val_d_i[33:0] when we_i[1]. Both may write in the same cycle. Writes are accepted in every state, and the regs are not cleared between ops.
- Adder: alu_adder_ext_o = {1'b0,alu_operand_a_i} + {1'b0,alu_operand_b_i}. This is combinational, with no mod-2^33 truncation before bit 33.
- busy_o = (state != IDLE).
- valid_i outside EXEC is ignored (assertion).
- Reset mid-op returns to IDLE. The unit shares rst_ni, so both sides restart together.

Test Plan:
- MULL A=7 B=6 signed=00 -> one wb_valid pulse with wb_data=42 (0x2A); mult_en_o high 3 cycles then low; div_en_o never high.
- MULH A=0xFFFFFFFE B=3 signed=11 -> wb_data=0xFFFFFFFF; mult_en_o high 4 cycles.
- DIV A=5 B=0 dit=0 -> equal_to_zero_o=1; wb_data=0xFFFFFFFF after the short path. DIV with dit=1 -> same result after the full 37-cycle path.
- REM A=0xFFFFFFF9 (-7) B=2 signed=11 -> wb_data=0xFFFFFFFF (-1). imd_val_q_o upper half tracks the remainder each EXEC cycle.
- wb_ready_i held low 5 cycles in RESP -> wb_valid_o and wb_data_o stable; on release a queued request is accepted the same cycle and busy_o stays 1.
- flush_i pulsed in the 10th EXEC cycle of DIV -> enables stay until valid_i; no wb_valid_o; returns to IDLE; the next MULL 3*3 returns 9.

Source files
------------

// File: rtl/ibex_multdiv_issue_ctrl.sv
// Issue-side controller for the fast multiply/divide unit: latches one request,
// drives the unit's enable/operand bus, lends it an adder and imd storage, and hands the result to writeback.
module ibex_multdiv_issue_ctrl #(
    parameter int DATA_W = 32,
    parameter int IMD_W  = 34
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [1:0]            req_op_i,
    input  logic [1:0]            req_signed_i,
    input  logic [DATA_W-1:0]     req_a_i,
    input  logic [DATA_W-1:0]     req_b_i,
    input  logic                  req_dit_i,
    input  logic                  flush_i,
    output logic                  mult_en_o,
    output logic                  div_en_o,
    output logic                  mult_sel_o,
    output logic                  div_sel_o,
    output logic [1:0]            operator_o,
    output logic [1:0]            signed_mode_o,
    output logic [DATA_W-1:0]     op_a_o,
    output logic [DATA_W-1:0]     op_b_o,
    output logic                  data_ind_timing_o,
    input  logic [DATA_W:0]       alu_operand_a_i,
    input  logic [DATA_W:0]       alu_operand_b_i,
    output logic [DATA_W+1:0]     alu_adder_ext_o,
    output logic [DATA_W-1:0]     alu_adder_o,
    output logic                  equal_to_zero_o,
    input  logic [2*IMD_W-1:0]    imd_val_d_i,
    input  logic [1:0]            imd_val_we_i,
    output logic [2*IMD_W-1:0]    imd_val_q_o,
    input  logic                  valid_i,
    input  logic [DATA_W-1:0]     result_i,
    output logic                  multdiv_ready_id_o,
    output logic                  wb_valid_o,
    input  logic                  wb_ready_i,
    output logic [DATA_W-1:0]     wb_data_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e              r_state;
    state_e              w_state_nxt;
    logic                r_kill;
    logic                w_kill_nxt;
    logic                w_latch;
    logic                w_capture;
    logic                w_req_ready;
    logic [1:0]          r_op;
    logic [1:0]          r_signed;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic                r_dit;
    logic [DATA_W-1:0]   r_wb_data;
    logic [2*IMD_W-1:0]  r_imd;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_kill  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_kill  <= w_kill_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_kill_nxt  = r_kill;
        w_latch     = 1'b0;
        w_capture   = 1'b0;
        w_req_ready = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid_i) begin
                    w_latch     = 1'b1;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                // A flushed op still runs to completion; only its result is dropped.
                if (valid_i) begin
                    w_capture   = 1'b1;
                    w_kill_nxt  = 1'b0;
                    w_state_nxt = (r_kill || flush_i) ? IDLE : RESP;
                end else if (flush_i) begin
                    w_kill_nxt = 1'b1;
                end
            end
            RESP: begin
                if (flush_i) begin
                    w_state_nxt = IDLE;
                end else if (wb_ready_i) begin
                    w_req_ready = 1'b1;
                    if (req_valid_i) begin
                        w_latch     = 1'b1;
                        w_state_nxt = EXEC;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_kill_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_op     <= '0;
            r_signed <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_dit    <= 1'b0;
        end else if (w_latch) begin
            r_op     <= req_op_i;
            r_signed <= req_signed_i;
            r_a      <= req_a_i;
            r_b      <= req_b_i;
            r_dit    <= req_dit_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wb_data <= '0;
        end else if (w_capture) begin
            r_wb_data <= result_i;
        end
    end

    // we[0] owns the upper register, we[1] the lower; they persist across ops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_imd <= '0;
        end else begin
            if (imd_val_we_i[0]) r_imd[2*IMD_W-1:IMD_W] <= imd_val_d_i[2*IMD_W-1:IMD_W];
            if (imd_val_we_i[1]) r_imd[IMD_W-1:0]       <= imd_val_d_i[IMD_W-1:0];
        end
    end

    assign req_ready_o        = w_req_ready;
    assign mult_en_o          = (r_state == EXEC) && !r_op[1];
    assign div_en_o           = (r_state == EXEC) &&  r_op[1];
    assign mult_sel_o         = mult_en_o;
    assign div_sel_o          = div_en_o;
    assign operator_o         = r_op;
    assign signed_mode_o      = r_signed;
    assign op_a_o             = r_a;
    assign op_b_o             = r_b;
    assign data_ind_timing_o  = r_dit;
    assign alu_adder_ext_o    = {1'b0, alu_operand_a_i} + {1'b0, alu_operand_b_i};
    assign alu_adder_o        = alu_adder_ext_o[DATA_W:1];
    assign equal_to_zero_o    = (r_b == '0);
    assign imd_val_q_o        = r_imd;
    assign multdiv_ready_id_o = (r_state == EXEC);
    assign wb_valid_o         = (r_state == RESP);
    assign wb_data_o          = r_wb_data;
    assign busy_o             = (r_state != IDLE);

`ifndef SYNTHESIS
    a_valid_only_in_exec: assert property (@(posedge clk_i) disable iff (!rst_ni)
        valid_i |-> (r_state == EXEC));
`endif

endmodule
